// File: rtl/perf_counter_bank.sv
// perf_counter_bank: memory-mapped performance counter block on one target
// port of the CPU address mux. A measurement window (start/stop/limit)
// gates a free-running cycle counter and NUM_EVENTS event counters.
//
// Ports:
//   clk    - system clock, all state on posedge
//   rst    - synchronous reset, active-high
//   ain    - word address; only ain[ADDR_W-1:0] decoded
//   din    - write data
//   wren   - write strobe
//   dout   - registered read data for the address presented last cycle
//   events - per-cycle event strobes
//   busy   - state == RUN
//   done   - state == DONE
//
// Map: 0 CTRL (W: b0 start, b1 stop, b2 clear; R: state), 1 LIMIT,
//      2 STATUS (sticky overflow, W1C), 3 CYCLE, 4.. EVENT[i].

// One counter lane: clear/increment with wrap, flags the wrap edge.
module perf_ctr_lane #(
  parameter int CNT_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);
  always_ff @(posedge clk) begin
    if (rst || clr)  cnt <= '0;
    else if (inc)    cnt <= cnt + CNT_W'(1);
  end

  // Set on the same edge the counter wraps from all-ones to zero.
  assign ovf = inc & (&cnt);
endmodule

module perf_counter_bank #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_W      = 48,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           ain,
  input  logic [63:0]           din,
  input  logic                  wren,
  output logic [63:0]           dout,
  input  logic [NUM_EVENTS-1:0] events,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NL = NUM_EVENTS + 1;  // lane 0 = cycles, lane i+1 = event i

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          limit;
  logic [NL-1:0]             status;
  logic [NL-1:0][CNT_W-1:0]  cnt;
  logic [NL-1:0]             ovf;
  logic [NL-1:0]             lane_inc;

  logic [ADDR_W-1:0] a;
  logic              wr_ctrl, wr_limit, wr_status;
  logic              c_start, c_stop, c_clr;
  logic              run, count_en, limit_hit;
  logic [CNT_W-1:0]  cyc_inc;
  logic [63:0]       rd_data;
  logic              unused_bits;

  assign a         = ain[ADDR_W-1:0];
  assign wr_ctrl   = wren && (a == ADDR_W'(0));
  assign wr_limit  = wren && (a == ADDR_W'(1));
  assign wr_status = wren && (a == ADDR_W'(2));
  assign c_start   = wr_ctrl & din[0];
  assign c_stop    = wr_ctrl & din[1];
  assign c_clr     = wr_ctrl & din[2];

  assign run       = (state == ST_RUN);
  // A control write in RUN still lets this cycle count, except clear.
  assign count_en  = run & ~c_clr;
  assign lane_inc  = count_en ? {events, 1'b1} : '0;

  // Compare against the post-increment cycle count, truncated to CNT_W,
  // so a LIMIT at or below the current count only hits after wrap.
  assign cyc_inc   = cnt[0] + CNT_W'(1);
  assign limit_hit = run && (limit != '0) && (cyc_inc == limit);

  for (genvar g = 0; g < NL; g++) begin : g_lane
    perf_ctr_lane #(.CNT_W(CNT_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (c_clr),
      .inc (lane_inc[g]),
      .cnt (cnt[g]),
      .ovf (ovf[g])
    );
  end

  // Clear beats everything; stop beats start; an explicit stop in RUN
  // beats a simultaneous limit hit. Start has no effect while running.
  always_comb begin
    state_nxt = state;
    if (c_clr)                        state_nxt = ST_IDLE;
    else if (run && c_stop)           state_nxt = ST_IDLE;
    else if (!run && c_start && !c_stop) state_nxt = ST_RUN;
    else if (limit_hit)               state_nxt = ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)           limit <= '0;
    else if (wr_limit) limit <= din[CNT_W-1:0];
  end

  // W1C is applied first, a same-edge overflow set wins over it.
  always_ff @(posedge clk) begin
    if (rst || c_clr)   status <= '0;
    else if (wr_status) status <= (status & ~din[NL-1:0]) | ovf;
    else                status <= status | ovf;
  end

  // Read mux uses pre-edge state, so read-during-write sees the old value.
  always_comb begin
    rd_data = '0;
    case (a)
      ADDR_W'(0): rd_data = {62'd0, state};
      ADDR_W'(1): rd_data = 64'(limit);
      ADDR_W'(2): rd_data = 64'(status);
      ADDR_W'(3): rd_data = 64'(cnt[0]);
      default: begin
        for (int i = 0; i < NUM_EVENTS; i++)
          if (a == ADDR_W'(4 + i)) rd_data = 64'(cnt[i+1]);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else     dout <= rd_data;
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  assign unused_bits = ^{ain[63:ADDR_W], din};
endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;
  localparam logic [63:0] MASK = (64'd1 << 48) - 64'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ain, din;
  logic        wren;
  logic [3:0]  events;
  logic [63:0] dout, dout8;
  logic        busy, done, busy8, done8;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_EVENTS(4), .CNT_W(48), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .ain(ain), .din(din), .wren(wren),
    .dout(dout), .events(events), .busy(busy), .done(done));

  perf_counter_bank #(.NUM_EVENTS(4), .CNT_W(8), .ADDR_W(4)) dut8 (
    .clk(clk), .rst(rst), .ain(ain), .din(din), .wren(wren),
    .dout(dout8), .events(events), .busy(busy8), .done(done8));

  // Reference model of the 48-bit instance, in plain integers.
  int          m_st;
  logic [63:0] m_lim, m_cyc, m_stat, m_dout;
  logic [63:0] m_ev [4];

  function automatic logic [63:0] model_read(input int a);
    case (a)
      0: return 64'(m_st);
      1: return m_lim;
      2: return m_stat;
      3: return m_cyc;
      4, 5, 6, 7: return m_ev[a-4];
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_step();
    int a;
    bit ctrl, start, stop, clr, run, hit;
    logic [63:0] rd, set;
    if (rst) begin
      m_st = 0; m_lim = 0; m_cyc = 0; m_stat = 0; m_dout = 0;
      for (int i = 0; i < 4; i++) m_ev[i] = 0;
      return;
    end
    a     = int'(ain[3:0]);
    rd    = model_read(a);
    ctrl  = wren && a == 0;
    start = ctrl && din[0];
    stop  = ctrl && din[1];
    clr   = ctrl && din[2];
    run   = (m_st == 1);
    set   = 0;
    hit   = 0;
    if (clr) begin
      m_cyc = 0; m_stat = 0; m_st = 0;
      for (int i = 0; i < 4; i++) m_ev[i] = 0;
    end else begin
      if (run) begin
        hit   = (m_lim != 0) && (((m_cyc + 1) & MASK) == m_lim);
        m_cyc = (m_cyc + 1) & MASK;
        if (m_cyc == 0) set[0] = 1'b1;
        for (int i = 0; i < 4; i++)
          if (events[i]) begin
            m_ev[i] = (m_ev[i] + 1) & MASK;
            if (m_ev[i] == 0) set[i+1] = 1'b1;
          end
      end
      if (wren && a == 2) m_stat = m_stat & ~(din & 64'h1f);
      m_stat = m_stat | set;
      if (run && stop)                  m_st = 0;
      else if (!run && start && !stop)  m_st = 1;
      else if (hit)                     m_st = 2;
    end
    if (wren && a == 1) m_lim = din & MASK;
    m_dout = rd;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock: drive, let the edge happen, update the model, sample at +1.
  task automatic cyc(input logic [63:0] a, input logic [63:0] d, input logic w,
                     input logic [3:0] e);
    ain = a; din = d; wren = w; events = e;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rd(input logic [63:0] a, input logic [3:0] e = 4'd0);
    cyc(a, 64'd0, 1'b0, e);
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [3:0] e = 4'd0);
    cyc(a, d, 1'b1, e);
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
    logic        w;
    logic [63:0] exp;
    logic        busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] d, input logic w,
                              input logic [63:0] exp, input logic b);
    vec_t v;
    v.a = a; v.d = d; v.w = w; v.exp = exp; v.busy = b;
    return v;
  endfunction

  initial begin
    // Register map, read latency and CTRL precedence from a clean reset.
    tbl.push_back(mk(0, 0, 0, 0, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0));
    tbl.push_back(mk(4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 3, 1, 0, 0));          // start+stop in IDLE
    tbl.push_back(mk(0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 64'h1234, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 64'h1234, 0));
    tbl.push_back(mk(1, 0, 1, 64'h1234, 0));   // read-during-write: old value
    tbl.push_back(mk(3, 55, 1, 0, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0));          // CYCLE write ignored
    tbl.push_back(mk(4, 9, 1, 0, 0));
    tbl.push_back(mk(4, 0, 0, 0, 0));
    tbl.push_back(mk(2, '1, 1, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0));
    tbl.push_back(mk(15, 0, 0, 0, 0));
    tbl.push_back(mk(9, 5, 1, 0, 0));
    tbl.push_back(mk(8, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1));          // start
    tbl.push_back(mk(0, 0, 0, 1, 1));
    tbl.push_back(mk(3, 0, 0, 1, 1));
    tbl.push_back(mk(0, 2, 1, 1, 0));          // stop, this cycle counted
    tbl.push_back(mk(3, 0, 0, 3, 0));
    tbl.push_back(mk(4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4, 1, 0, 0));          // clear
    tbl.push_back(mk(3, 0, 0, 0, 0));

    // 1: reset
    rst = 1'b1; ain = 0; din = 0; wren = 0; events = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst = 1'b0;
    chk("reset dout", dout, 0);
    chk("reset busy", 64'(busy), 0);
    chk("reset done", 64'(done), 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].a, tbl[i].d, tbl[i].w, 4'd0);
      chk($sformatf("tbl%0d dout", i), dout, tbl[i].exp);
      chk($sformatf("tbl%0d busy", i), 64'(busy), 64'(tbl[i].busy));
    end

    // 2: free run of 10 counted cycles on event 0
    wr(0, 1, 4'b0001);
    for (int i = 0; i < 9; i++) rd(3, 4'b0001);
    wr(0, 2, 4'b0001);
    chk("freerun busy", 64'(busy), 0);
    rd(3); chk("freerun CYCLE", dout, 10);
    rd(4); chk("freerun EVENT0", dout, 10);
    rd(5); chk("freerun EVENT1", dout, 0);
    rd(0); chk("freerun CTRL", dout, 0);

    // 3: limit of 5
    wr(1, 5);
    wr(0, 4);
    wr(0, 1, 4'hf);
    for (int i = 1; i <= 5; i++) begin
      rd(3, 4'hf);
      if (i == 4) begin
        chk("limit done early", 64'(done), 0);
        chk("limit busy", 64'(busy), 1);
      end
    end
    chk("limit done", 64'(done), 1);
    chk("limit busy off", 64'(busy), 0);
    rd(3, 4'hf); chk("limit CYCLE", dout, 5);
    rd(7, 4'hf); chk("limit EVENT3", dout, 5);
    rd(0);       chk("limit CTRL", dout, 2);
    chk("limit done holds", 64'(done), 1);
    wr(1, 0);
    wr(0, 4);
    chk("clear from DONE", 64'(done), 0);

    // 4: overflow on the 8-bit instance, 256 counted cycles of event 2
    wr(0, 1, 4'b0100);
    for (int i = 0; i < 255; i++) rd(3, 4'b0100);
    wr(0, 2, 4'b0100);
    chk("ovf busy8", 64'(busy8), 0);
    chk("ovf done8", 64'(done8), 0);
    rd(6); chk("ovf EVENT2 w8", dout8, 0);
    rd(3); chk("ovf CYCLE w8", dout8, 0);
    chk("ovf CYCLE w48", dout, 256);
    rd(2); chk("ovf STATUS w8", dout8, 9);
    chk("ovf STATUS w48", dout, 0);
    wr(2, 8); chk("ovf W1C old", dout8, 9);
    rd(2);    chk("ovf STATUS after W1C", dout8, 1);
    wr(0, 4);

    // 6: clear during RUN, then reset during RUN
    wr(0, 1);
    for (int i = 0; i < 3; i++) rd(3, 4'b0001);
    wr(0, 7, 4'b0001);
    chk("ctrl7 busy", 64'(busy), 0);
    rd(3); chk("ctrl7 CYCLE", dout, 0);
    rd(4); chk("ctrl7 EVENT0", dout, 0);
    wr(1, 100);
    wr(0, 1);
    for (int i = 0; i < 3; i++) rd(3, 4'b0001);
    rst = 1'b1;
    rd(3, 4'b0001);
    rst = 1'b0;
    chk("rst busy", 64'(busy), 0);
    chk("rst dout", dout, 0);
    rd(0); chk("rst CTRL", dout, 0);
    rd(1); chk("rst LIMIT", dout, 0);
    rd(3); chk("rst CYCLE", dout, 0);
    rd(4); chk("rst EVENT0", dout, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      logic [63:0] a, d;
      logic        w;
      a = 64'($urandom_range(0, 15));
      w = 1'($urandom_range(0, 1));
      if (a == 0) begin
        d = 64'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) d = d | 64'd4;
      end else if (a == 1) d = 64'($urandom_range(0, 40));
      else d = {$urandom, $urandom};
      rst = ($urandom_range(0, 299) == 0);
      cyc(a, d, w, 4'($urandom_range(0, 15)));
      chk("rand dout", dout, m_dout);
      chk("rand busy", 64'(busy), 64'(m_st == 1));
      chk("rand done", 64'(done), 64'(m_st == 2));
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
